wb_tgt_mem: RTL and testbench
=============================

Name: wb_tgt_mem

Overview:
- Pipelined Wishbone target (responder) model: a small word-addressed memory with byte-lane writes, a fixed response latency and a bounded number of outstanding requests.
- It is the far end of the initiator-side protocol rules the team's target monitor checks.
- It sits on the target side of crossbar components in benches, paired with the target monitor, so those rules can be exercised against a real responder with stall, err and abort behaviour.

Parameters:
ADR_WIDTH, 16, address bus width; must be >= MEM_AW
DAT_WIDTH, 16, data bus width; must be a multiple of SEL_WIDTH
SEL_WIDTH, 2, number of byte-lane selects
TGA_WIDTH, 1, address tag width
TGC_WIDTH, 1, cycle tag width (accepted, ignored)
TGRD_WIDTH, 1, read data tag width
TGWD_WIDTH, 1, write data tag width (accepted, ignored)
MEM_AW, 8, memory depth is 2**MEM_AW words
LATENCY, 2, cycles from acceptance to termination; >= 1
MAX_OUTST, 2, maximum outstanding requests; 1..LATENCY

Ports:
clk_i  in  1  module clock
async_rst_i  in  1  asynchronous reset, active low
tgt_cyc_i  in  1  bus cycle indicator
tgt_stb_i  in  1  access request
tgt_we_i  in  1  write enable
tgt_lock_i  in  1  uninterruptable cycle (accepted, ignored)
tgt_sel_i  in  SEL_WIDTH  byte-lane selects
tgt_adr_i  in  ADR_WIDTH  word address
tgt_dat_i  in  DAT_WIDTH  write data
tgt_tga_i  in  TGA_WIDTH  address tags
tgt_tgc_i  in  TGC_WIDTH  cycle tags
tgt_tgd_i  in  TGWD_WIDTH  write data tags
tgt_ack_o  out  1  acknowledge
tgt_err_o  out  1  error termination
tgt_rty_o  out  1  retry; constant 0
tgt_stall_o  out  1  pipeline stall
tgt_dat_o  out  DAT_WIDTH  read data
tgt_tgd_o  out  TGRD_WIDTH  read data tag

Behaviour:
- Reset (async_rst_i low):
  - All delay-line valids = 0, outstanding count = 0, memory cleared to 0.
  - ack_o = err_o = rty_o = stall_o = 0; dat_o and tgd_o = 0.
- Accept condition: cyc_i & stb_i & ~stall_o, sampled at the rising edge.
- Out-of-range request: adr_i[ADR_WIDTH-1:MEM_AW] != 0. Flagged err; no memory write.
- Write, in range, at the acceptance edge: each lane k with sel_i[k]=1 updates bits [k*W +: W], where W = DAT_WIDTH/SEL_WIDTH.
- Read at acceptance: sample mem[adr] before any same-edge write. Strict in-order semantics: a read sees every earlier write. Reads with err return data 0.
- Response entry {err, rdata, tgd = tga_i zero-extended or truncated to TGRD_WIDTH} enters stage 1 of a LATENCY-deep delay line. The entry's termination appears in cycle t+LATENCY if accepted in cycle t.
- Outputs from the last stage:
  - ack_o = valid & ~err & cyc_i
  - err_o = valid & err & cyc_i
  - dat_o and tgd_o are held from the last stage; undefined when not ack.
  - ack_o and err_o are never both high.
- Outstanding count: +1 on accept, -1 when the last stage is valid; both may occur in the same cycle, leaving the count unchanged.
- tgt_stall_o = cyc_i & (count >= MAX_OUTST), using the registered count. It is conservative: it remains high in a cycle where a response retires.
- Abort: cyc_i low in any cycle clears all valids and the count at the next edge. No termination is issued for aborted requests. Writes already performed remain.
- lock_i, tgc_i and tgd_i have no effect.
- While stall_o is high, stb_i and request signals may be held; the request is accepted in the first cycle stall_o is low.

Decomposition:
- Package wb_tgt_mem_pkg: response-entry struct {err, dat, tgd} and a localparam for lane width.
- One sub-module, wb_tgt_dly: a parameterised LATENCY-stage valid/data delay line with synchronous flush. The memory, range check and counter stay in the top.

Test Plan:
- Write 0xBEEF to adr 0x0010, sel=2'b11 -> ack 2 cycles after acceptance. Read 0x0010 -> ack with dat_o=0xBEEF.
- Write 0x1234 sel=2'b01 to adr 0x0010 (holding 0xBEEF) -> read returns 0xBE34.
- Back-to-back stb over 4 cycles (W 0x20=0x1111, R 0x20, W 0x21=0x2222, R 0x21):
  - stall_o asserted while 2 requests are outstanding.
  - Exactly 4 acks, in order.
  - Reads return 0x1111 and 0x2222.
- Read adr 0x0100 (out of range with MEM_AW=8) -> err_o=1, ack_o=0. A write to 0x0100 leaves mem[0x00] unchanged.
- Accept 2 reads, then drop cyc_i for 1 cycle before termination -> no ack/err. Count returns to 0 and stall_o=0.
- Drive async_rst_i low mid-burst -> all outputs 0 immediately. After release, reading any address returns 0x0000.

Source files
------------

// File: rtl/wb_tgt_mem_pkg.sv
// Shared types for the Wishbone target memory model.
// The response entry carries everything the delay line must hold for one
// accepted request: the error flag, the read data and the read data tag.
// The field widths below define the data/tag widths this model supports.
package wb_tgt_mem_pkg;

   localparam int unsigned RSP_DAT_WIDTH = 16;
   localparam int unsigned RSP_TGD_WIDTH = 1;
   localparam int unsigned RSP_SEL_WIDTH = 2;

   // Bits per byte lane.
   localparam int unsigned LANE_WIDTH = RSP_DAT_WIDTH / RSP_SEL_WIDTH;

   typedef struct packed {
      logic                     err;
      logic [RSP_DAT_WIDTH-1:0] dat;
      logic [RSP_TGD_WIDTH-1:0] tgd;
   } rsp_entry_t;

   localparam int unsigned RSP_ENTRY_WIDTH = $bits(rsp_entry_t);

endpackage

// File: rtl/wb_tgt_dly.sv
// Fixed-latency valid/data delay line with synchronous flush.
// Ports:
//   clk_i, async_rst_i  clock, asynchronous active-low reset
//   flush               clears every stage valid at the next edge
//   in_valid, in_data   entry written into stage 1
//   out_valid, out_data last stage (LATENCY edges after entry)
module wb_tgt_dly #(
   parameter int unsigned LATENCY = 2,
   parameter int unsigned DW      = 1
) (
   input  logic          clk_i,
   input  logic          async_rst_i,
   input  logic          flush,
   input  logic          in_valid,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   output logic [DW-1:0] out_data
);

   logic [LATENCY-1:0] vld_q;
   logic [DW-1:0]      dat_q [LATENCY];

   // Shift register; data shifts unconditionally, only valids are flushed.
   always_ff @(posedge clk_i or negedge async_rst_i) begin
      if (!async_rst_i) begin
         vld_q <= '0;
         for (int i = 0; i < int'(LATENCY); i++) begin
            dat_q[i] <= '0;
         end
      end else begin
         vld_q[0] <= in_valid & ~flush;
         dat_q[0] <= in_data;
         for (int i = 1; i < int'(LATENCY); i++) begin
            vld_q[i] <= vld_q[i-1] & ~flush;
            dat_q[i] <= dat_q[i-1];
         end
      end
   end

   assign out_valid = vld_q[LATENCY-1];
   assign out_data  = dat_q[LATENCY-1];

endmodule

// File: rtl/wb_tgt_mem.sv
// Pipelined Wishbone target memory model.
// Word-addressed memory with byte-lane writes, fixed response latency,
// bounded outstanding requests, err on out-of-range addresses and
// abort (cyc drop) handling.
// Ports:
//   clk_i, async_rst_i       clock, asynchronous active-low reset
//   tgt_cyc_i/stb_i/we_i     cycle, strobe, write enable
//   tgt_lock_i, tgt_tgc_i,
//   tgt_tgd_i                accepted, no effect
//   tgt_sel_i/adr_i/dat_i    byte selects, word address, write data
//   tgt_tga_i                address tag, returned on tgt_tgd_o
//   tgt_ack_o/err_o/rty_o    terminations (rty is always 0)
//   tgt_stall_o              outstanding limit reached
//   tgt_dat_o/tgd_o          read data and tag of the terminating entry
module wb_tgt_mem
   import wb_tgt_mem_pkg::*;
#(
   parameter int unsigned ADR_WIDTH  = 16,
   parameter int unsigned DAT_WIDTH  = RSP_DAT_WIDTH,
   parameter int unsigned SEL_WIDTH  = RSP_SEL_WIDTH,
   parameter int unsigned TGA_WIDTH  = 1,
   parameter int unsigned TGC_WIDTH  = 1,
   parameter int unsigned TGRD_WIDTH = RSP_TGD_WIDTH,
   parameter int unsigned TGWD_WIDTH = 1,
   parameter int unsigned MEM_AW     = 8,
   parameter int unsigned LATENCY    = 2,
   parameter int unsigned MAX_OUTST  = 2
) (
   input  logic                  clk_i,
   input  logic                  async_rst_i,
   input  logic                  tgt_cyc_i,
   input  logic                  tgt_stb_i,
   input  logic                  tgt_we_i,
   input  logic                  tgt_lock_i,
   input  logic [SEL_WIDTH-1:0]  tgt_sel_i,
   input  logic [ADR_WIDTH-1:0]  tgt_adr_i,
   input  logic [DAT_WIDTH-1:0]  tgt_dat_i,
   input  logic [TGA_WIDTH-1:0]  tgt_tga_i,
   input  logic [TGC_WIDTH-1:0]  tgt_tgc_i,
   input  logic [TGWD_WIDTH-1:0] tgt_tgd_i,
   output logic                  tgt_ack_o,
   output logic                  tgt_err_o,
   output logic                  tgt_rty_o,
   output logic                  tgt_stall_o,
   output logic [DAT_WIDTH-1:0]  tgt_dat_o,
   output logic [TGRD_WIDTH-1:0] tgt_tgd_o
);

   localparam int unsigned DEPTH = 2 ** MEM_AW;
   localparam int unsigned CNT_W = $clog2(MAX_OUTST + 1);

   logic [DAT_WIDTH-1:0] mem_q [DEPTH];
   logic [CNT_W-1:0]     cnt_q;
   logic [CNT_W-1:0]     cnt_d;
   logic                 accept;
   logic                 retire;
   logic                 flush;
   logic                 out_of_range;
   logic [MEM_AW-1:0]    idx;
   logic [DAT_WIDTH-1:0] rdata;
   rsp_entry_t           in_entry;
   rsp_entry_t           out_entry;
   logic                 out_valid;

   // Inputs that are part of the bus but deliberately ignored.
   logic unused_inputs;
   assign unused_inputs = ^{tgt_lock_i, tgt_tgc_i, tgt_tgd_i};

   // Any set address bit above the memory index is out of range.
   generate
      if (ADR_WIDTH > MEM_AW) begin : g_range
         assign out_of_range = |tgt_adr_i[ADR_WIDTH-1:MEM_AW];
      end else begin : g_no_range
         assign out_of_range = 1'b0;
      end
   endgenerate

   assign idx    = tgt_adr_i[MEM_AW-1:0];
   assign flush  = ~tgt_cyc_i;
   assign accept = tgt_cyc_i & tgt_stb_i & ~tgt_stall_o;
   assign retire = out_valid;

   // Read samples the array before this edge's write lands.
   assign rdata = out_of_range ? '0 : mem_q[idx];

   // Byte-lane memory write at the acceptance edge.
   always_ff @(posedge clk_i or negedge async_rst_i) begin
      if (!async_rst_i) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else if (accept && tgt_we_i && !out_of_range) begin
         for (int k = 0; k < int'(SEL_WIDTH); k++) begin
            if (tgt_sel_i[k]) begin
               mem_q[idx][k*LANE_WIDTH +: LANE_WIDTH] <= tgt_dat_i[k*LANE_WIDTH +: LANE_WIDTH];
            end
         end
      end
   end

   // Response entry for the request presented this cycle.
   always_comb begin
      in_entry     = '0;
      in_entry.err = out_of_range;
      in_entry.dat = RSP_DAT_WIDTH'(rdata);
      in_entry.tgd = RSP_TGD_WIDTH'(tgt_tga_i);
   end

   wb_tgt_dly #(
      .LATENCY (LATENCY),
      .DW      (RSP_ENTRY_WIDTH)
   ) u_dly (
      .clk_i       (clk_i),
      .async_rst_i (async_rst_i),
      .flush       (flush),
      .in_valid    (accept),
      .in_data     (in_entry),
      .out_valid   (out_valid),
      .out_data    (out_entry)
   );

   // Outstanding count; an abort wipes it together with the delay line.
   always_comb begin
      cnt_d = cnt_q;
      if (flush) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(accept) - CNT_W'(retire);
      end
   end

   always_ff @(posedge clk_i or negedge async_rst_i) begin
      if (!async_rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Registered count only: stays high even in a retiring cycle.
   assign tgt_stall_o = tgt_cyc_i & (cnt_q >= CNT_W'(MAX_OUTST));

   assign tgt_ack_o = out_valid & ~out_entry.err & tgt_cyc_i;
   assign tgt_err_o = out_valid &  out_entry.err & tgt_cyc_i;
   assign tgt_rty_o = 1'b0;
   assign tgt_dat_o = DAT_WIDTH'(out_entry.dat);
   assign tgt_tgd_o = TGRD_WIDTH'(out_entry.tgd);

endmodule

// File: tb/tb_wb_tgt_mem.sv
// Scoreboard bench for wb_tgt_mem: the driver pushes expected terminations
// when a request is accepted, the monitor pops and compares on ack/err.
`timescale 1ns/1ps
module tb_wb_tgt_mem;

   localparam int LAT = 2;

   logic        clk_i = 1'b0;
   logic        async_rst_i = 1'b0;
   logic        tgt_cyc_i = 1'b0;
   logic        tgt_stb_i = 1'b0;
   logic        tgt_we_i = 1'b0;
   logic        tgt_lock_i = 1'b0;
   logic [1:0]  tgt_sel_i = '0;
   logic [15:0] tgt_adr_i = '0;
   logic [15:0] tgt_dat_i = '0;
   logic [0:0]  tgt_tga_i = '0;
   logic [0:0]  tgt_tgc_i = '0;
   logic [0:0]  tgt_tgd_i = '0;
   logic        tgt_ack_o;
   logic        tgt_err_o;
   logic        tgt_rty_o;
   logic        tgt_stall_o;
   logic [15:0] tgt_dat_o;
   logic [0:0]  tgt_tgd_o;

   wb_tgt_mem #(
      .ADR_WIDTH (16), .DAT_WIDTH (16), .SEL_WIDTH (2), .TGA_WIDTH (1),
      .TGC_WIDTH (1), .TGRD_WIDTH (1), .TGWD_WIDTH (1), .MEM_AW (8),
      .LATENCY (2), .MAX_OUTST (2)
   ) dut (
      .clk_i       (clk_i),
      .async_rst_i (async_rst_i),
      .tgt_cyc_i   (tgt_cyc_i),
      .tgt_stb_i   (tgt_stb_i),
      .tgt_we_i    (tgt_we_i),
      .tgt_lock_i  (tgt_lock_i),
      .tgt_sel_i   (tgt_sel_i),
      .tgt_adr_i   (tgt_adr_i),
      .tgt_dat_i   (tgt_dat_i),
      .tgt_tga_i   (tgt_tga_i),
      .tgt_tgc_i   (tgt_tgc_i),
      .tgt_tgd_i   (tgt_tgd_i),
      .tgt_ack_o   (tgt_ack_o),
      .tgt_err_o   (tgt_err_o),
      .tgt_rty_o   (tgt_rty_o),
      .tgt_stall_o (tgt_stall_o),
      .tgt_dat_o   (tgt_dat_o),
      .tgt_tgd_o   (tgt_tgd_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      bit          err;
      bit          chk_dat;
      logic [15:0] dat;
      logic        tgd;
      int          due;
      string       nm;
   } exp_t;

   exp_t sb[$];
   int   n_checks   = 0;
   int   n_pass     = 0;
   int   cycle      = 0;
   int   stall_seen = 0;
   int   n_term     = 0;

   always @(posedge clk_i) cycle <= cycle + 1;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
   endtask

   // Monitor: every termination must match the oldest expected entry.
   exp_t e;
   always @(negedge clk_i) begin
      if (async_rst_i && (tgt_ack_o || tgt_err_o)) begin
         n_term++;
         check("ack_err_exclusive", 32'(tgt_ack_o & tgt_err_o), 32'd0);
         if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_term: ack=%0b err=%0b at cycle %0d, expected none",
                     tgt_ack_o, tgt_err_o, cycle);
         end else begin
            e = sb.pop_front();
            check({e.nm, "_err"},   32'(tgt_err_o), 32'(e.err));
            check({e.nm, "_cycle"}, 32'(cycle),     32'(e.due));
            if (e.chk_dat) begin
               check({e.nm, "_dat"}, 32'(tgt_dat_o), 32'(e.dat));
               check({e.nm, "_tgd"}, 32'(tgt_tgd_o), 32'(e.tgd));
            end
         end
      end
   end

   // Present a request and hold it until accepted; returns just after the accepting edge.
   task automatic req(input bit we, input logic [15:0] adr, input logic [15:0] dat,
                      input logic [1:0] sel, input logic tga, input bit push,
                      input bit e_err, input logic [15:0] e_dat, input string nm);
      exp_t x;
      bit   done = 1'b0;
      tgt_cyc_i = 1'b1;
      tgt_stb_i = 1'b1;
      tgt_we_i  = we;
      tgt_adr_i = adr;
      tgt_dat_i = dat;
      tgt_sel_i = sel;
      tgt_tga_i = tga;
      for (int k = 0; k < 40 && !done; k++) begin
         @(negedge clk_i);
         if (!tgt_stall_o) begin
            if (push) begin
               x.err     = e_err;
               x.chk_dat = !we && !e_err;
               x.dat     = e_dat;
               x.tgd     = tga;
               x.due     = cycle + LAT;
               x.nm      = nm;
               sb.push_back(x);
            end
            done = 1'b1;
         end else begin
            stall_seen++;
         end
      end
      if (!done) begin
         n_checks++;
         $display("FAIL %s_accept: stall_o still 1 after 40 cycles, expected 0", nm);
      end
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle();
      tgt_stb_i = 1'b0;
      tgt_we_i  = 1'b0;
   endtask

   task automatic drain(input string nm);
      for (int k = 0; k < 60 && sb.size() != 0; k++) @(posedge clk_i);
      if (sb.size() != 0) begin
         n_checks++;
         $display("FAIL %s_drain: %0d responses outstanding, expected 0", nm, sb.size());
         sb.delete();
      end
      repeat (2) @(posedge clk_i);
      #1;
   endtask

   task automatic check_all_zero(input string nm);
      check({nm, "_ack"},   32'(tgt_ack_o),   32'd0);
      check({nm, "_err"},   32'(tgt_err_o),   32'd0);
      check({nm, "_rty"},   32'(tgt_rty_o),   32'd0);
      check({nm, "_stall"}, 32'(tgt_stall_o), 32'd0);
      check({nm, "_dat"},   32'(tgt_dat_o),   32'd0);
      check({nm, "_tgd"},   32'(tgt_tgd_o),   32'd0);
   endtask

   initial begin
      int t0;
      repeat (2) @(posedge clk_i);
      #1;
      check_all_zero("reset");
      @(negedge clk_i);
      async_rst_i = 1'b1;
      @(posedge clk_i);
      #1;
      tgt_cyc_i = 1'b1;

      // Full-word write then read back, tag returned.
      req(1'b1, 16'h0010, 16'hBEEF, 2'b11, 1'b0, 1'b1, 1'b0, 16'h0000, "w_beef");
      idle(); drain("w_beef");
      req(1'b0, 16'h0010, 16'h0000, 2'b11, 1'b1, 1'b1, 1'b0, 16'hBEEF, "r_beef");
      idle(); drain("r_beef");

      // Low lane only.
      req(1'b1, 16'h0010, 16'h1234, 2'b01, 1'b0, 1'b1, 1'b0, 16'h0000, "w_lane0");
      req(1'b0, 16'h0010, 16'h0000, 2'b11, 1'b0, 1'b1, 1'b0, 16'hBE34, "r_be34");
      idle(); drain("lane");

      // Back-to-back burst hits the outstanding limit.
      stall_seen = 0;
      t0 = n_term;
      req(1'b1, 16'h0020, 16'h1111, 2'b11, 1'b0, 1'b1, 1'b0, 16'h0000, "b_w20");
      req(1'b0, 16'h0020, 16'h0000, 2'b11, 1'b1, 1'b1, 1'b0, 16'h1111, "b_r20");
      req(1'b1, 16'h0021, 16'h2222, 2'b11, 1'b0, 1'b1, 1'b0, 16'h0000, "b_w21");
      req(1'b0, 16'h0021, 16'h0000, 2'b11, 1'b0, 1'b1, 1'b0, 16'h2222, "b_r21");
      idle(); drain("burst");
      check("burst_stall_seen", 32'(stall_seen != 0), 32'd1);
      check("burst_terms", 32'(n_term - t0), 32'd4);

      // Out-of-range read and write terminate with err; mem[0] untouched.
      req(1'b1, 16'h0000, 16'hA5A5, 2'b11, 1'b0, 1'b1, 1'b0, 16'h0000, "w_00");
      req(1'b0, 16'h0100, 16'h0000, 2'b11, 1'b0, 1'b1, 1'b1, 16'h0000, "r_oor");
      req(1'b1, 16'h0100, 16'hFFFF, 2'b11, 1'b0, 1'b1, 1'b1, 16'h0000, "w_oor");
      req(1'b0, 16'h0000, 16'h0000, 2'b11, 1'b0, 1'b1, 1'b0, 16'hA5A5, "r_00");
      idle(); drain("oor");

      // Abort two reads by dropping cyc for one cycle.
      req(1'b0, 16'h0010, 16'h0000, 2'b11, 1'b0, 1'b0, 1'b0, 16'h0000, "ab_r0");
      req(1'b0, 16'h0020, 16'h0000, 2'b11, 1'b0, 1'b0, 1'b0, 16'h0000, "ab_r1");
      tgt_cyc_i = 1'b0;
      idle();
      @(posedge clk_i);
      #1;
      tgt_cyc_i = 1'b1;
      check("abort_stall_o", 32'(tgt_stall_o), 32'd0);
      stall_seen = 0;
      req(1'b0, 16'h0010, 16'h0000, 2'b11, 1'b0, 1'b1, 1'b0, 16'hBE34, "pa_r10");
      req(1'b0, 16'h0020, 16'h0000, 2'b11, 1'b0, 1'b1, 1'b0, 16'h1111, "pa_r20");
      idle(); drain("post_abort");
      check("post_abort_no_stall", 32'(stall_seen), 32'd0);

      // Asynchronous reset in the middle of a burst.
      req(1'b0, 16'h0010, 16'h0000, 2'b11, 1'b1, 1'b1, 1'b0, 16'hBE34, "rst_r0");
      req(1'b0, 16'h0020, 16'h0000, 2'b11, 1'b1, 1'b1, 1'b0, 16'h1111, "rst_r1");
      #1;
      async_rst_i = 1'b0;
      #1;
      check_all_zero("midrst");
      sb.delete();
      idle();
      @(posedge clk_i);
      #3;
      async_rst_i = 1'b1;
      @(posedge clk_i);
      #1;
      req(1'b0, 16'h0010, 16'h0000, 2'b11, 1'b0, 1'b1, 1'b0, 16'h0000, "pr_r10");
      req(1'b0, 16'h0020, 16'h0000, 2'b11, 1'b0, 1'b1, 1'b0, 16'h0000, "pr_r20");
      req(1'b0, 16'h0000, 16'h0000, 2'b11, 1'b0, 1'b1, 1'b0, 16'h0000, "pr_r00");
      idle(); drain("post_reset");

      check("sb_empty", 32'(sb.size()), 32'd0);
      check("rty_const", 32'(tgt_rty_o), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish by 200000 ns");
      $fatal(1, "timeout");
   end

endmodule
